btn_debounce: RTL and testbench

Two-channel push-button conditioner that sits directly upstream of the button-combining logic driving the LEDs. It synchronises the raw asynchronous board buttons into the clock domain, filters contact bounce with a per-channel stability counter, and produces clean debounced levels plus single-cycle press/release pulses. The debounced levels connect straight to the downstream `btn0`/`btn1` inputs.

---
 rtl/btn_debounce.sv | 144 ++++++++++++++
 tb/tb_btn_debounce.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: two-channel push-button conditioner.
// Each raw button passes through a two-flop synchroniser and a stability
// counter. A new level is accepted only after it has held for DEBOUNCE_CYCLES
// consecutive synchronised cycles. Acceptance produces one-cycle rise/fall pulses.
// Optional long-press detection is compiled in when the macro BTN_HOLD_EN
// is defined. Otherwise btn_hold is tied low.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_db,
    output logic [1:0] btn_rise,
    output logic [1:0] btn_fall,
    output logic [1:0] btn_hold
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Both counters need at least one bit and a terminal count above zero
    generate
        if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_cfg
            $error("btn_debounce: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 2");
        end
    endgenerate

    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       db_q;
    logic [1:0]       db_d;
    logic [1:0]       rise_q;
    logic [1:0]       rise_d;
    logic [1:0]       fall_q;
    logic [1:0]       fall_d;

    // Bring the asynchronous buttons into the clk domain through two flops
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count how long the synchronised level has disagreed with the accepted
    // level, and accept it (with an edge pulse) once the count reaches its end
    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 2'b00;
        fall_d = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] == db_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                cnt_d[ch]  = '0;
                db_d[ch]   = sync2_q[ch];
                rise_d[ch] = sync2_q[ch];
                fall_d[ch] = ~sync2_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // Register the counters, accepted levels and edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch] <= '0;
            end
            db_q   <= 2'b00;
            rise_q <= 2'b00;
            fall_q <= 2'b00;
        end else begin
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign btn_db   = db_q;
    assign btn_rise = rise_q;
    assign btn_fall = fall_q;

`ifdef BTN_HOLD_EN
    localparam int                HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q [2];
    logic [HOLD_W-1:0] hold_cnt_d [2];
    logic [1:0]        hold_done_q;
    logic [1:0]        hold_done_d;
    logic [1:0]        hold_q;
    logic [1:0]        hold_d;

    // Time each debounced press. Fire once at the terminal count, then park
    // there until release so that a long press yields a single pulse
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        hold_done_d = hold_done_q;
        hold_d      = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            if (!db_q[ch]) begin
                hold_cnt_d[ch]  = '0;
                hold_done_d[ch] = 1'b0;
            end else if (hold_cnt_q[ch] == HOLD_LAST) begin
                hold_d[ch]      = ~hold_done_q[ch];
                hold_done_d[ch] = 1'b1;
            end else begin
                hold_cnt_d[ch] = hold_cnt_q[ch] + HOLD_W'(1);
            end
        end
    end

    // Register the hold counters, saturation flags and long-press pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                hold_cnt_q[ch] <= '0;
            end
            hold_done_q <= 2'b00;
            hold_q      <= 2'b00;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            hold_done_q <= hold_done_d;
            hold_q      <= hold_d;
        end
    end

    assign btn_hold = hold_q;
`else
    assign btn_hold = 2'b00;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed bench for btn_debounce with a window-based
// reference model. The model says a level is accepted once the last
// DEB synchronised samples all differ from the accepted level.
// It says a long press fires when the accepted level has been high for HOLD edges.
module tb_btn_debounce;

    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic       clk;
    logic       rst;
    logic [1:0] btn_raw;
    logic [1:0] btn_db;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic [1:0] btn_hold;

    int total = 0;
    int bad   = 0;
    int edgeNo = 0;

    logic [1:0] mS1   = 2'b00;
    logic [1:0] mDb   = 2'b00;
    logic [1:0] mRise = 2'b00;
    logic [1:0] mFall = 2'b00;
    logic [1:0] mHold = 2'b00;
    int         runLen [2] = '{0, 0};
    logic [1:0] s2Hist [$];

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .btn_hold(btn_hold)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of synchronised samples plus accepted level
    always @(posedge clk) begin
        logic [1:0] newS2;
        logic       allFlip;
        edgeNo++;
        newS2 = rst ? 2'b00 : mS1;
        mS1   = rst ? 2'b00 : btn_raw;
        for (int ch = 0; ch < 2; ch++) begin
            mRise[ch] = 1'b0;
            mFall[ch] = 1'b0;
            mHold[ch] = 1'b0;
            if (rst) begin
                mDb[ch]    = 1'b0;
                runLen[ch] = 0;
            end else begin
`ifdef BTN_HOLD_EN
                mHold[ch] = (runLen[ch] == HOLD);
`endif
                allFlip = (s2Hist.size() == DEB);
                foreach (s2Hist[j]) begin
                    if (s2Hist[j][ch] == mDb[ch]) allFlip = 1'b0;
                end
                if (allFlip) begin
                    mDb[ch]   = ~mDb[ch];
                    mRise[ch] = mDb[ch];
                    mFall[ch] = ~mDb[ch];
                end
                runLen[ch] = mDb[ch] ? runLen[ch] + 1 : 0;
            end
        end
        s2Hist.push_back(newS2);
        if (s2Hist.size() > DEB) void'(s2Hist.pop_front());
    end

    task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, edgeNo, act, exp);
        end
    endtask

    // Compare every DUT output against the model after each edge
    always @(negedge clk) begin
        if (edgeNo > 0) begin
            checkOutput("modelDb",   btn_db,   mDb);
            checkOutput("modelRise", btn_rise, mRise);
            checkOutput("modelFall", btn_fall, mFall);
            checkOutput("modelHold", btn_hold, mHold);
        end
    end

    task automatic applyStimulus(input logic r, input logic [1:0] raw);
        rst     = r;
        btn_raw = raw;
    endtask

    task automatic waitEdge(input int target);
        while (edgeNo < target) @(negedge clk);
    endtask

    // Drive a new raw level and pin the deadline 5 edges after its capture
    task automatic qualify(input logic [1:0] raw, input logic [1:0] expDb,
                           input logic [1:0] expRise, input logic [1:0] expFall);
        int k;
        applyStimulus(1'b0, raw);
        k = edgeNo + 1;
        waitEdge(k + 4);
        checkOutput("dbEarly",    btn_db, expDb ^ (expRise | expFall));
        checkOutput("pulseEarly", btn_rise | btn_fall, 2'b00);
        waitEdge(k + 5);
        checkOutput("dbDeadline",   btn_db,   expDb);
        checkOutput("riseDeadline", btn_rise, expRise);
        checkOutput("fallDeadline", btn_fall, expFall);
        waitEdge(k + 6);
        checkOutput("pulseWidth", btn_rise | btn_fall, 2'b00);
    endtask

    // Watchdog so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int k;
        int e;
        logic [1:0] expHold;
`ifdef BTN_HOLD_EN
        expHold = 2'b01;
`else
        expHold = 2'b00;
`endif
        // Reset held 3 edges with both buttons pressed
        applyStimulus(1'b1, 2'b11);
        for (int i = 1; i <= 3; i++) begin
            waitEdge(i);
            checkOutput("resetOutputs", btn_db | btn_rise | btn_fall | btn_hold, 2'b00);
        end
        applyStimulus(1'b0, 2'b11);
        waitEdge(8);
        checkOutput("postResetDbEarly", btn_db, 2'b00);
        waitEdge(9);
        checkOutput("postResetDb",   btn_db,   2'b11);
        checkOutput("postResetRise", btn_rise, 2'b11);
        waitEdge(10);
        checkOutput("postResetRiseGone", btn_rise, 2'b00);

        // Release both, then clean press/release on channel 0
        qualify(2'b00, 2'b00, 2'b00, 2'b11);
        repeat (5) @(negedge clk);
        qualify(2'b01, 2'b01, 2'b01, 2'b00);
        repeat (24) @(negedge clk);
        qualify(2'b00, 2'b00, 2'b00, 2'b01);

        // Three-cycle glitch on channel 1 must be ignored
        applyStimulus(1'b0, 2'b10);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 2'b00);
        repeat (10) @(negedge clk);
        checkOutput("glitchDb", btn_db, 2'b00);

        // Bounce on channel 0, then a steady press
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, {1'b0, ((i / 2) % 2) == 0});
            @(negedge clk);
        end
        checkOutput("bounceDb", btn_db, 2'b00);
        qualify(2'b01, 2'b01, 2'b01, 2'b00);
        qualify(2'b00, 2'b00, 2'b00, 2'b01);

        // Simultaneous press and release
        repeat (3) @(negedge clk);
        qualify(2'b11, 2'b11, 2'b11, 2'b00);
        qualify(2'b00, 2'b00, 2'b00, 2'b11);

        // Simultaneous press with reset 2 cycles after capture
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 2'b11);
        k = edgeNo + 1;
        waitEdge(k + 1);
        applyStimulus(1'b1, 2'b11);
        waitEdge(k + 3);
        applyStimulus(1'b0, 2'b11);
        waitEdge(k + 5);
        checkOutput("abortedDb",   btn_db,   2'b00);
        checkOutput("abortedRise", btn_rise, 2'b00);
        waitEdge(k + 8);
        checkOutput("requalDbEarly", btn_db, 2'b00);
        waitEdge(k + 9);
        checkOutput("requalDb",   btn_db,   2'b11);
        checkOutput("requalRise", btn_rise, 2'b11);
        qualify(2'b00, 2'b00, 2'b00, 2'b11);

        // Long press on channel 0
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 2'b01);
        k = edgeNo + 1;
        e = k + 5;
        waitEdge(e);
        checkOutput("holdPressDb", btn_db, 2'b01);
        waitEdge(e + 15);
        checkOutput("holdEarly", btn_hold, 2'b00);
        waitEdge(e + 16);
        checkOutput("holdPulse", btn_hold, expHold);
        waitEdge(e + 17);
        checkOutput("holdOnce", btn_hold, 2'b00);
        waitEdge(k + 40);
        applyStimulus(1'b0, 2'b00);
        repeat (10) @(negedge clk);

        // Short press on channel 0 never reaches the long-press point
        applyStimulus(1'b0, 2'b01);
        k = edgeNo + 1;
        waitEdge(k + 10);
        applyStimulus(1'b0, 2'b00);
        waitEdge(k + 21);
        checkOutput("shortPressHold", btn_hold, 2'b00);
        checkOutput("shortPressDb",   btn_db,   2'b00);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
